dpram_port_arbiter: RTL and testbench
=====================================

Name: dpram_port_arbiter

Overview:
- Shares the synchronous read/write port of the team's simple dual-port RAM (1-cycle registered read, write-enable plus address) between NUM_REQ requesters, using a round-robin valid/ready handshake.
- Returns read data to the winning requester one cycle after acceptance.
- Zero-fills the whole RAM after reset and on demand, and holds off all requesters while the fill runs.
- Sits directly in front of the RAM port; the other RAM port is untouched.

Parameters:
- ADDR_WIDTH, 6, RAM address width; depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 14, RAM word width.
- NUM_REQ, 3, number of requesters (2..8).

Ports:
- clk  in  1  single clock for the block and the RAM port.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_we  in  NUM_REQ  per-requester write (1) / read (0).
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed addresses; requester i occupies slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- req_wdata  in  NUM_REQ*DATA_WIDTH  packed write data, same slicing.
- rsp_valid  out  NUM_REQ  one-hot read-response strobe.
- rsp_data  out  DATA_WIDTH  read data, valid when any rsp_valid bit is set.
- clear_start  in  1  pulse requesting a full zero-fill.
- busy  out  1  high while a fill is in progress.
- mem_addr  out  ADDR_WIDTH  to RAM port address.
- mem_we  out  1  to RAM port write enable.
- mem_wdata  out  DATA_WIDTH  to RAM port write data.
- mem_rdata  in  DATA_WIDTH  from RAM port registered read data.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-low (rst_n).
- Reset values: FSM=CLEAR, clear counter=0, priority pointer=0, rsp_valid=0, busy=1.
  - Combinational outputs follow from state: req_ready=0, mem_we=1, mem_addr=0, mem_wdata=0.
- FSM states: CLEAR, SERVE.
- CLEAR:
  - Each cycle: mem_we=1, mem_addr=counter, mem_wdata=0; counter increments.
  - When counter = 2**ADDR_WIDTH-1 the write is issued, then the FSM goes to SERVE next cycle with counter reset to 0.
  - Fill takes exactly 2**ADDR_WIDTH cycles. busy=1 throughout; req_ready=0.
- SERVE:
  - busy=0.
  - clear_start=1 moves the FSM to CLEAR next cycle. Any request accepted in that same cycle still completes, including its response.
- Arbitration (combinational, SERVE only):
  - Search starts at the priority pointer p: first i in order p, p+1, ... (mod NUM_REQ) with req_valid[i]=1 wins.
  - req_ready[winner]=1; all other bits 0.
  - mem_addr, mem_we and mem_wdata are driven from the winner's slices.
  - With no valid request: mem_we=0, mem_addr holds its last value, req_ready=0.
- Handshake:
  - A transfer occurs on valid&ready.
  - After a transfer by requester i, p becomes (i+1) mod NUM_REQ. p is unchanged if there is no transfer.
  - Requesters must hold their valid/addr/data stable until ready. A requester may drop valid without penalty.
- Read latency:
  - A read accepted in cycle N gives rsp_valid[i]=1 in cycle N+1 with rsp_data=mem_rdata.
  - The winner index is registered for this purpose.
  - Back-to-back reads produce one response per cycle, in acceptance order.
  - Writes produce no response.
- Read-during-write, same address, same port: returns old data (the RAM's read-before-write behaviour). The arbiter adds no bypass.
- clear_start behaviour:
  - Ignored while busy=1; it does not restart the fill.
  - A request pending when CLEAR begins waits; its valid must stay held.
- Reset mid-fill: asynchronous abort, restart from address 0. Any response that would have been due is dropped.
- rsp_data when no rsp_valid bit is set: don't-care. Drive it from mem_rdata.

Test Plan:
- Reset release with NUM_REQ=3, ADDR_WIDTH=6 -> busy high for exactly 64 cycles; mem_we=1 with addresses 0..63 and data 0; then busy=0. Reading address 63 afterwards returns 0.
- All three requesters valid continuously, reads from addresses 5/6/7 -> grants follow 0,1,2,0,1,2. Each rsp_valid arrives one cycle after its grant, with data matching the prior writes.
- Requester 1 writes 0x2ABC to address 10, then requester 2 reads address 10 -> rsp_valid=3'b100 with rsp_data=0x2ABC one cycle after the read grant.
- clear_start pulsed in the same cycle requester 0 is granted a read -> that read response is still delivered. Then a 64-cycle fill runs, req_ready=0 throughout, and the previously written address reads 0.
- rst_n asserted at fill address 20 and released -> fill restarts at address 0 and takes a full 64 cycles. rsp_valid=0 immediately on assertion.
- Only requester 2 valid while p=0, then requester 0 valid -> requester 2 is granted first, p becomes 0, and requester 0 is granted next.

Source files
------------

// File: rtl/dpram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dpram_port_arbiter                                               |
// | Purpose : Round-robin sharing of one synchronous RAM port, with zero-fill.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module dpram_port_arbiter #(
    parameter int ADDR_WIDTH = 6,
    parameter int DATA_WIDTH = 14,
    parameter int NUM_REQ    = 3
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
    output logic [NUM_REQ-1:0]             rsp_valid,
    output logic [DATA_WIDTH-1:0]          rsp_data,
    input  logic                           clear_start,
    output logic                           busy,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    output logic                           mem_we,
    output logic [DATA_WIDTH-1:0]          mem_wdata,
    input  logic [DATA_WIDTH-1:0]          mem_rdata
);

    localparam int                    c_IDX_W     = $clog2(NUM_REQ);
    localparam logic [c_IDX_W-1:0]    c_LAST_IDX  = c_IDX_W'(NUM_REQ - 1);
    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = '1;

    localparam logic [0:0] c_ST_CLEAR = 1'b0;
    localparam logic [0:0] c_ST_SERVE = 1'b1;

    logic [0:0]            r_state;
    logic [0:0]            w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic [ADDR_WIDTH-1:0] r_last_addr;
    logic [c_IDX_W-1:0]    r_ptr;
    logic [c_IDX_W-1:0]    w_win_idx;
    logic [c_IDX_W-1:0]    w_cand;
    logic                  w_win_found;
    logic                  w_xfer;
    logic [NUM_REQ-1:0]    r_rsp_valid;
    logic [ADDR_WIDTH-1:0] w_addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] w_wdata_arr [NUM_REQ];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign w_addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_CLEAR: if (r_cnt == c_LAST_ADDR) w_state_nxt = c_ST_SERVE;
            default:    if (clear_start)          w_state_nxt = c_ST_CLEAR;
        endcase
    end

    // Round-robin search starting at the priority pointer
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        w_cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = c_IDX_W'((32'(r_ptr) + k) % NUM_REQ);
            if (!w_win_found && req_valid[w_cand]) begin
                w_win_found = 1'b1;
                w_win_idx   = w_cand;
            end
        end
    end

    assign w_xfer = (r_state == c_ST_SERVE) && w_win_found;

    // Output logic
    always_comb begin
        req_ready = '0;
        mem_we    = 1'b0;
        mem_addr  = r_last_addr;
        mem_wdata = '0;
        busy      = 1'b0;
        case (r_state)
            c_ST_CLEAR: begin
                busy     = 1'b1;
                mem_we   = 1'b1;
                mem_addr = r_cnt;
            end
            default: begin
                if (w_win_found) begin
                    req_ready[w_win_idx] = 1'b1;
                    mem_we               = req_we[w_win_idx];
                    mem_addr             = w_addr_arr[w_win_idx];
                    mem_wdata            = w_wdata_arr[w_win_idx];
                end
            end
        endcase
    end

    // Fill counter wraps back to zero on the final fill write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (r_state == c_ST_CLEAR) begin
            r_cnt <= r_cnt + 1'b1;
        end else begin
            r_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_xfer) begin
            r_ptr <= (w_win_idx == c_LAST_IDX) ? '0 : w_win_idx + 1'b1;
        end
    end

    // Registered one-hot winner marks whose read data arrives next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= '0;
        end else begin
            r_rsp_valid <= '0;
            if (w_xfer && !req_we[w_win_idx]) begin
                r_rsp_valid[w_win_idx] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_addr <= '0;
        end else begin
            r_last_addr <= mem_addr;
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = mem_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dpram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_dpram_port_arbiter                                            |
// | Purpose : Scoreboard bench for dpram_port_arbiter with a behavioural RAM.  |
// | Revision: 1.0 - initial release                                            |
// +----------------------------------------------------------------------------+
module tb_dpram_port_arbiter;

    localparam int AW    = 6;
    localparam int DW    = 14;
    localparam int NR    = 3;
    localparam int DEPTH = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_data;
    logic              clear_start;
    logic              busy;
    logic [AW-1:0]     mem_addr;
    logic              mem_we;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    always #5 clk = ~clk;

    dpram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_REQ(NR)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .clear_start(clear_start), .busy(busy),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    // Read-before-write synchronous RAM port
    logic [DW-1:0] ram [DEPTH];
    always @(posedge clk) begin
        mem_rdata <= ram[mem_addr];
        if (mem_we) ram[mem_addr] <= mem_wdata;
    end

    typedef struct packed { logic we; logic [AW-1:0] addr; logic [DW-1:0] data; } op_t;
    typedef struct { int idx; logic [DW-1:0] data; int cyc; } rsp_t;

    op_t   opq [NR][$];
    rsp_t  rspq [$];

    bit            m_busy;
    int            m_cnt;
    int            m_ptr;
    logic [AW-1:0] m_last_addr;
    logic [DW-1:0] ref_mem [DEPTH];
    logic [NR-1:0] acc;
    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    int            ck_w;
    int            ck_c;
    logic [AW-1:0] ck_a;
    logic [DW-1:0] ck_d;
    rsp_t          ck_e;
    rsp_t          mon_r;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // Reference model: round-robin rule, fill sequence and memory contents
    always @(negedge clk) begin
        if (rst_n !== 1'b1) begin
            acc = '0;
        end else begin
            acc = req_ready & req_valid;
            chk("busy", busy, m_busy);
            if (m_busy) begin
                chk("fill_ready", req_ready, 0);
                chk("fill_we", mem_we, 1);
                chk("fill_addr", mem_addr, m_cnt);
                chk("fill_wdata", mem_wdata, 0);
                ref_mem[m_cnt] = '0;
                m_last_addr = AW'(m_cnt);
                if (m_cnt == DEPTH - 1) begin
                    m_busy = 1'b0;
                    m_cnt  = 0;
                end else begin
                    m_cnt++;
                end
            end else begin
                ck_w = -1;
                for (int k = 0; k < NR; k++) begin
                    ck_c = (m_ptr + k) % NR;
                    if (ck_w < 0 && req_valid[ck_c]) ck_w = ck_c;
                end
                if (ck_w >= 0) begin
                    ck_a = req_addr[ck_w*AW +: AW];
                    ck_d = req_wdata[ck_w*DW +: DW];
                    chk("grant", req_ready, 1 << ck_w);
                    chk("mem_we", mem_we, req_we[ck_w]);
                    chk("mem_addr", mem_addr, ck_a);
                    if (req_we[ck_w]) begin
                        chk("mem_wdata", mem_wdata, ck_d);
                        ref_mem[ck_a] = ck_d;
                    end else begin
                        ck_e.idx  = ck_w;
                        ck_e.data = ref_mem[ck_a];
                        ck_e.cyc  = cyc;
                        rspq.push_back(ck_e);
                    end
                    m_ptr = (ck_w + 1) % NR;
                    m_last_addr = ck_a;
                end else begin
                    chk("idle_ready", req_ready, 0);
                    chk("idle_we", mem_we, 0);
                    chk("idle_addr", mem_addr, m_last_addr);
                end
                if (clear_start) begin
                    m_busy = 1'b1;
                    m_cnt  = 0;
                end
            end
        end
    end

    // Response monitor
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rsp_valid != '0) begin
                if (rspq.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL rsp_unexpected: got rsp_valid %b expected none (cycle %0d)", rsp_valid, cyc);
                end else begin
                    mon_r = rspq.pop_front();
                    chk("rsp_valid", rsp_valid, 1 << mon_r.idx);
                    chk("rsp_data", rsp_data, mon_r.data);
                    chk("rsp_latency", cyc - mon_r.cyc, 1);
                end
            end else if (rspq.size() != 0 && rspq[0].cyc == cyc - 1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL rsp_missing: got rsp_valid 0 expected %0d (cycle %0d)", 1 << rspq[0].idx, cyc);
                mon_r = rspq.pop_front();
            end
        end
    end

    task automatic push(input int i, input bit we, input int addr, input int data);
        op_t o;
        o.we   = we;
        o.addr = AW'(addr);
        o.data = DW'(data);
        opq[i].push_back(o);
    endtask

    // Advance one cycle; requesters hold each op until it is accepted
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (acc[i] && opq[i].size() > 0) opq[i].delete(0);
            if (opq[i].size() > 0) begin
                req_valid[i]           = 1'b1;
                req_we[i]              = opq[i][0].we;
                req_addr[i*AW +: AW]   = opq[i][0].addr;
                req_wdata[i*DW +: DW]  = opq[i][0].data;
            end else begin
                req_valid[i] = 1'b0;
            end
        end
    endtask

    function automatic bit pending();
        bit p;
        p = (rspq.size() != 0) || m_busy || (req_valid != '0);
        for (int i = 0; i < NR; i++) if (opq[i].size() != 0) p = 1'b1;
        return p;
    endfunction

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (pending() && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) fail_now("drain_timeout");
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < NR; i++) opq[i].delete();
        rspq.delete();
        req_valid   = '0;
        clear_start = 1'b0;
        acc         = '0;
        m_busy      = 1'b1;
        m_cnt       = 0;
        m_ptr       = 0;
    endtask

    initial begin
        int n;
        rst_n       = 1'b0;
        req_valid   = '0;
        req_we      = '0;
        req_addr    = '0;
        req_wdata   = '0;
        clear_start = 1'b0;
        acc         = '0;
        m_busy      = 1'b1;
        m_cnt       = 0;
        m_ptr       = 0;
        m_last_addr = '0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_mem_we", mem_we, 1);
        chk("rst_mem_addr", mem_addr, 0);
        rst_n = 1'b1;
        wait_drain(200);

        push(0, 0, 63, 0);                 wait_drain(50);
        push(1, 1, 10, 14'h2ABC);          wait_drain(50);
        push(2, 0, 10, 0);                 wait_drain(50);

        push(0, 1, 5, 14'h0155); push(0, 1, 6, 14'h0266); push(0, 1, 7, 14'h0377);
        wait_drain(50);
        push(2, 1, 8, 14'h1888);           wait_drain(50);
        for (int r = 0; r < 2; r++) begin
            push(0, 0, 5, 0); push(1, 0, 6, 0); push(2, 0, 7, 0);
        end
        wait_drain(50);
        push(2, 0, 6, 0);                  wait_drain(50);
        push(0, 0, 5, 0);                  wait_drain(50);

        // Fill requested in the same cycle as a read grant
        push(0, 0, 10, 0);
        step();
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        wait_drain(200);
        push(1, 0, 10, 0);                 wait_drain(50);

        for (int c = 0; c < 1500; c++) begin
            step();
            clear_start = ($urandom_range(0, 199) == 0);
            for (int i = 0; i < NR; i++) begin
                if (opq[i].size() < 2 && $urandom_range(0, 2) == 0)
                    push(i, $urandom_range(0, 1), $urandom_range(0, 15), $urandom);
            end
        end
        clear_start = 1'b0;
        wait_drain(500);

        // Reset while a read response is on the bus
        push(0, 0, 10, 0);
        step();
        step();
        chk("pre_reset_rsp", rsp_valid, 1);
        #1;
        do_reset();
        #1;
        chk("reset_rsp_drop", rsp_valid, 0);
        chk("reset_busy", busy, 1);
        repeat (2) step();
        rst_n = 1'b1;
        wait_drain(200);

        // Reset in the middle of a fill
        clear_start = 1'b1;
        step();
        clear_start = 1'b0;
        n = 0;
        while (!(m_busy && m_cnt == 20) && n < 100) begin
            step();
            n++;
        end
        if (n >= 100) fail_now("fill_wait_timeout");
        chk("abort_addr", mem_addr, 20);
        #1;
        do_reset();
        #1;
        chk("abort_rsp_valid", rsp_valid, 0);
        chk("abort_restart_addr", mem_addr, 0);
        chk("abort_busy", busy, 1);
        step();
        rst_n = 1'b1;
        wait_drain(200);
        push(0, 0, 63, 0); push(2, 0, 10, 0);
        wait_drain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete (cycle %0d)", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
